// File: rtl/nonce_uplink_arbiter.sv
// nonce_uplink_arbiter
//  Shares one uplink serial transmitter between SLAVES nonce sources. Each
//  source's nonce is captured on its new_nonces strobe and held until sent.
//  Grants rotate round-robin. The send/busy-rise/busy-fall handshake is
//  sequenced so that no word is lost or duplicated.
//
//  Optional feature macro: ARB_DROP_COUNT_EN adds a saturating drop_count output.
//
//  Ports
//   hash_clk      in   sole clock, rising edge
//   rst_n         in   async active-low reset
//   slave_nonces  in   SLAVES*32, slave i at [i*32+31:i*32]
//   new_nonces    in   SLAVES, 1-cycle strobe per slave
//   tx_busy       in   transmitter busy
//   tx_send       out  1-cycle send request
//   tx_word       out  32-bit word being transmitted
//   pending       out  SLAVES, per-slave unsent-nonce flags
//   grant_idx     out  PTR_W, slave currently/last being sent
//   drop_count    out  16, overwrites of unsent nonces (ARB_DROP_COUNT_EN only)
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  IDLE       | waiting for a pending nonce and a free uplink
//  WAIT_RISE  | send issued, waiting for tx_busy to rise (bounded by timeout)
//  WAIT_FALL  | transmitter busy with our word, waiting for it to finish
module nonce_uplink_arbiter #(
   parameter int SLAVES       = 2,
   parameter int PTR_W        = 1,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                  hash_clk,
   input  logic                  rst_n,
   input  logic [SLAVES*32-1:0]  slave_nonces,
   input  logic [SLAVES-1:0]     new_nonces,
   input  logic                  tx_busy,
   output logic                  tx_send,
   output logic [31:0]           tx_word,
   output logic [SLAVES-1:0]     pending,
   output logic [PTR_W-1:0]      grant_idx
`ifdef ARB_DROP_COUNT_EN
   ,
   output logic [15:0]           drop_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_RISE = 2'd1,
      ST_WAIT_FALL = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    rr_q, rr_d;
   logic [PTR_W-1:0]    grant_q, grant_d;
   logic [7:0]          tmr_q, tmr_d;
   logic                tx_send_q, tx_send_d;
   logic [31:0]         tx_word_q, tx_word_d;
   logic [SLAVES-1:0]   pending_q, pending_d;
   logic [31:0]         hold_q [SLAVES];

   logic                gnt_vld;
   logic [PTR_W-1:0]    gnt_idx;
   logic [SLAVES-1:0]   clr_mask;

   // Round-robin pick: walk offsets from the far end so the smallest offset
   // from rr_q is the last assignment and therefore wins.
   always_comb begin
      int unsigned j;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      j       = 0;
      for (int k = SLAVES - 1; k >= 0; k--) begin
         j = (int'(rr_q) + k) % SLAVES;
         if (pending_q[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = PTR_W'(j);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      grant_d   = grant_q;
      tmr_d     = tmr_q;
      tx_word_d = tx_word_q;
      tx_send_d = 1'b0;
      clr_mask  = '0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld && !tx_busy) begin
               tx_send_d         = 1'b1;
               tx_word_d         = hold_q[gnt_idx];
               grant_d           = gnt_idx;
               clr_mask[gnt_idx] = 1'b1;
               rr_d              = (gnt_idx == PTR_W'(SLAVES - 1)) ? '0 : gnt_idx + PTR_W'(1);
               tmr_d             = 8'(BUSY_TIMEOUT - 1);
               state_d           = ST_WAIT_RISE;
            end
         end
         ST_WAIT_RISE: begin
            // A transmitter that never acknowledges must not stall the uplink;
            // the word is then considered sent.
            if (tx_busy)
               state_d = ST_WAIT_FALL;
            else if (tmr_q == 8'd0)
               state_d = ST_IDLE;
            else
               tmr_d = tmr_q - 8'd1;
         end
         ST_WAIT_FALL: begin
            if (!tx_busy)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A strobe in the same cycle as the grant re-arms the flag: capture wins.
   assign pending_d = (pending_q & ~clr_mask) | new_nonces;

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rr_q      <= '0;
         grant_q   <= '0;
         tmr_q     <= 8'd0;
         tx_send_q <= 1'b0;
         tx_word_q <= 32'd0;
         pending_q <= '0;
         for (int i = 0; i < SLAVES; i++)
            hold_q[i] <= 32'd0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         grant_q   <= grant_d;
         tmr_q     <= tmr_d;
         tx_send_q <= tx_send_d;
         tx_word_q <= tx_word_d;
         pending_q <= pending_d;
         for (int i = 0; i < SLAVES; i++)
            if (new_nonces[i])
               hold_q[i] <= slave_nonces[i*32 +: 32];
      end
   end

`ifdef ARB_DROP_COUNT_EN
   logic [15:0]       drop_q, drop_d;
   logic [SLAVES-1:0] ovr;
   logic [16:0]       drop_sum;

   // A nonce being granted this cycle is not lost, so it is not a drop.
   always_comb begin
      ovr      = new_nonces & pending_q & ~clr_mask;
      drop_sum = {1'b0, drop_q} + 17'($countones(ovr));
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge hash_clk or negedge rst_n) begin
      if (!rst_n)
         drop_q <= 16'd0;
      else
         drop_q <= drop_d;
   end

   assign drop_count = drop_q;
`endif

   assign tx_send   = tx_send_q;
   assign tx_word   = tx_word_q;
   assign pending   = pending_q;
   assign grant_idx = grant_q;

endmodule

// File: tb/tb_nonce_uplink_arbiter.sv
module tb_nonce_uplink_arbiter;

   localparam int NS = 4;
   localparam int TO = 15;

   logic          hash_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [127:0]  slave_nonces = '0;
   logic [3:0]    new_nonces = '0;
   logic          tx_busy = 1'b0;
   logic          tx_send;
   logic [31:0]   tx_word;
   logic [3:0]    pending;
   logic [1:0]    grant_idx;
`ifdef ARB_DROP_COUNT_EN
   logic [15:0]   drop_count;
`endif

   nonce_uplink_arbiter #(.SLAVES(NS), .PTR_W(2), .BUSY_TIMEOUT(TO)) dut (
      .hash_clk     (hash_clk),
      .rst_n        (rst_n),
      .slave_nonces (slave_nonces),
      .new_nonces   (new_nonces),
      .tx_busy      (tx_busy),
      .tx_send      (tx_send),
      .tx_word      (tx_word),
      .pending      (pending),
      .grant_idx    (grant_idx)
`ifdef ARB_DROP_COUNT_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   always #5 hash_clk = ~hash_clk;

   int errors = 0;
   int checks = 0;

   // Reference model: per-slave mailboxes, a rotation pointer and the
   // transmitter handshake phase (0 idle, 1 awaiting busy, 2 awaiting release).
   logic [31:0] m_hold [NS];
   bit   [3:0]  m_pend;
   int          m_rr, m_phase, m_wait;
   bit          e_send;
   logic [31:0] e_word;
   int          e_grant, e_drop;

   // Bench transmitter: goes busy for busy_len cycles after each expected send.
   int xmit_left = 0;
   int busy_len  = 10;
   bit foreign_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) m_hold[i] = '0;
      m_pend = '0; m_rr = 0; m_phase = 0; m_wait = 0;
      e_send = 0; e_word = '0; e_grant = 0; e_drop = 0;
   endtask

   task automatic model_edge();
      bit busy;
      logic [3:0] stb;
      int g;
      busy = tx_busy;
      stb  = new_nonces;
      g    = -1;
      e_send = 0;
      if (m_phase == 0) begin
         if (!busy)
            for (int k = 0; k < NS; k++)
               if (g < 0 && m_pend[(m_rr + k) % NS]) g = (m_rr + k) % NS;
         if (g >= 0) begin
            e_send = 1; e_word = m_hold[g]; e_grant = g;
            m_pend[g] = 0; m_rr = (g + 1) % NS; m_phase = 1; m_wait = 0;
         end
      end else if (m_phase == 1) begin
         if (busy) m_phase = 2;
         else begin
            m_wait++;
            if (m_wait >= TO) m_phase = 0;
         end
      end else begin
         if (!busy) m_phase = 0;
      end
      for (int i = 0; i < NS; i++)
         if (stb[i]) begin
            if (m_pend[i] && e_drop < 65535) e_drop++;
            m_hold[i] = slave_nonces[i*32 +: 32];
            m_pend[i] = 1;
         end
   endtask

   task automatic compare_all();
      chk("tx_send", 32'(tx_send), 32'(e_send));
      chk("tx_word", tx_word, e_word);
      chk("pending", 32'(pending), 32'(m_pend));
      chk("grant_idx", 32'(grant_idx), 32'(e_grant));
`ifdef ARB_DROP_COUNT_EN
      chk("drop_count", 32'(drop_count), 32'(e_drop));
`endif
   endtask

   task automatic cycle(input logic [3:0] stb, input logic [127:0] nz);
      new_nonces   = stb;
      slave_nonces = nz;
      @(posedge hash_clk);
      if (!rst_n) model_reset();
      else model_edge();
      #1;
      compare_all();
      new_nonces   = '0;
      slave_nonces = '0;
      if (xmit_left > 0) xmit_left--;
      if (e_send && busy_len > 0) xmit_left = busy_len;
      tx_busy = (xmit_left > 0) || foreign_busy;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(4'b0000, '0);
   endtask

   function automatic logic [127:0] pk(input int s, input logic [31:0] v);
      logic [127:0] r;
      r = '0;
      r[s*32 +: 32] = v;
      return r;
   endfunction

   task automatic wait_send(input int max, output int n);
      n = 0;
      do begin
         cycle(4'b0000, '0);
         n++;
      end while (!tx_send && n < max);
      checks++;
      if (!tx_send) begin
         errors++;
         $display("FAIL wait_send: no tx_send within %0d cycles", max);
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) cycle(4'b0000, '0);
      rst_n = 1'b1;
   endtask

   initial begin
      int n, sends;
      model_reset();

      // 1 reset values
      do_reset(3);
      chk("rst tx_send", 32'(tx_send), 32'd0);
      chk("rst tx_word", tx_word, 32'd0);
      chk("rst pending", 32'(pending), 32'd0);
      chk("rst grant", 32'(grant_idx), 32'd0);

      // 2 single nonce: send two cycles after strobe
      cycle(4'b0001, pk(0, 32'hDEADBEEF));
      chk("single pending", 32'(pending), 32'h1);
      cycle(4'b0000, '0);
      chk("single send", 32'(tx_send), 32'd1);
      chk("single word", tx_word, 32'hDEADBEEF);
      sends = 0;
      for (int i = 0; i < 14; i++) begin
         cycle(4'b0000, '0);
         if (tx_send) sends++;
      end
      chk("single no resend", 32'(sends), 32'd0);
      chk("single word held", tx_word, 32'hDEADBEEF);

      // 3 simultaneous strobes from pointer 0
      do_reset(2);
      cycle(4'b1010, pk(1, 32'h11) | pk(3, 32'h33));
      wait_send(5, n);
      chk("sim first word", tx_word, 32'h11);
      chk("sim first grant", 32'(grant_idx), 32'd1);
      wait_send(30, n);
      chk("sim second word", tx_word, 32'h33);
      chk("sim second grant", 32'(grant_idx), 32'd3);
      idle(15);
      cycle(4'b0101, pk(0, 32'h50) | pk(2, 32'h52));
      wait_send(5, n);
      chk("rr wrap grant", 32'(grant_idx), 32'd0);
      chk("rr wrap word", tx_word, 32'h50);
      wait_send(30, n);
      chk("rr next grant", 32'(grant_idx), 32'd2);
      idle(15);

      // 4 overwrite while uplink busy with another word
      cycle(4'b0010, pk(1, 32'h77));
      cycle(4'b0000, '0);
      chk("ovw other word", tx_word, 32'h77);
      cycle(4'b0001, pk(0, 32'hA));
      cycle(4'b0001, pk(0, 32'hB));
      wait_send(30, n);
      chk("ovw newest word", tx_word, 32'hB);
      chk("ovw grant", 32'(grant_idx), 32'd0);
`ifdef ARB_DROP_COUNT_EN
      chk("ovw drop_count", 32'(drop_count), 32'd1);
`endif
      idle(15);

      // 5 collision: strobe on the grant cycle
      cycle(4'b0001, pk(0, 32'hA));
      cycle(4'b0001, pk(0, 32'hC));
      chk("col send", 32'(tx_send), 32'd1);
      chk("col old word", tx_word, 32'hA);
      chk("col pending kept", 32'(pending), 32'h1);
      wait_send(30, n);
      chk("col new word", tx_word, 32'hC);
      idle(15);

      // 6a timeout: transmitter never answers; queued word goes 16 cycles later
      busy_len = 0;
      cycle(4'b0100, pk(2, 32'h66));
      wait_send(5, n);
      chk("to word", tx_word, 32'h66);
      cycle(4'b1000, pk(3, 32'h99));
      wait_send(30, n);
      chk("to gap", 32'(n + 1), 32'd16);
      chk("to next word", tx_word, 32'h99);
      idle(16);

      // 6b reset while transmitter busy
      busy_len = 10;
      cycle(4'b0010, pk(1, 32'h1234));
      wait_send(5, n);
      cycle(4'b0100, pk(2, 32'h5555));
      idle(1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid rst tx_send", 32'(tx_send), 32'd0);
      chk("mid rst tx_word", tx_word, 32'd0);
      chk("mid rst pending", 32'(pending), 32'd0);
      chk("mid rst grant", 32'(grant_idx), 32'd0);
      cycle(4'b0000, '0);
      cycle(4'b0000, '0);
      rst_n = 1'b1;
      cycle(4'b0001, pk(0, 32'h42));
      wait_send(30, n);
      chk("post rst word", tx_word, 32'h42);
      idle(15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
